button_conditioner: RTL and testbench

//   Input-side conditioner for the game's pushbuttons (up/down/pause and future keys).
//   - Synchronizes raw asynchronous pad inputs to clk and debounces each one.
//   - Outputs a clean level, a one-cycle press pulse, a one-cycle release pulse, and an

---
 rtl/button_conditioner_pkg.sv | 23 ++
 rtl/button_channel.sv | 130 +++++++++++++
 rtl/button_conditioner.sv | 37 +++
 tb/tb_button_conditioner.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: repeat FSM states and
// the counter-width helper used by every channel.
package button_conditioner_pkg;

  // Per-channel auto-repeat state.
  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    HELD_DELAY = 2'd1,
    HELD_RPT   = 2'd2
  } rpt_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One width serves both the debounce and the repeat counter.
  function automatic int cnt_width(input int db, input int rd, input int rr);
    return $clog2(max3(db, rd, rr) + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchronizer, debounce counter and the
// auto-repeat state machine. All outputs are registered.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter int DB_CYCLES    = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int CW = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_RATE);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RR_LAST  = CW'(REPEAT_RATE - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          accept, rise, fall;

  rpt_state_t    state, state_nxt;
  logic [CW-1:0] rcnt, rcnt_nxt;
  logic          rpt_nxt;

  // A change is accepted once s2 has disagreed with the level for DB_CYCLES edges.
  assign accept = (s2 != level) && (cnt == DB_LAST);
  assign rise   = accept &&  s2;
  assign fall   = accept && !s2;

  // Synchronizer, debounce counter, level and press/release pulses.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every flop reading the pre-edge
      // value of its neighbours, which is what makes s1->s2 a real 2-stage pipe.
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= btn_raw;
      s2    <= s1;
      press <= rise;
      rel   <= fall;
      if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else if (s2 != level) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  // Repeat FSM state, counter and registered repeat pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RELEASED;
      rcnt  <= '0;
      rpt   <= 1'b0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
      rpt   <= rpt_nxt;
    end
  end

  // Next-state logic; release wins over a coincident repeat tick, and a low
  // repeat_en wins over a tick.
  always_comb begin
    // NOTE: defaults first so every path assigns every output - no latches.
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rpt_nxt   = 1'b0;
    unique case (state)
      RELEASED: begin
        rcnt_nxt = '0;
        if (rise) begin
          rpt_nxt   = 1'b1;
          state_nxt = HELD_DELAY;
        end
      end
      HELD_DELAY: begin
        if (fall) begin
          rcnt_nxt  = '0;
          state_nxt = RELEASED;
        end else if (!repeat_en) begin
          rcnt_nxt = '0;
        end else if (rcnt == RD_LAST) begin
          rpt_nxt   = 1'b1;
          rcnt_nxt  = '0;
          state_nxt = HELD_RPT;
        end else begin
          rcnt_nxt = rcnt + CW'(1);
        end
      end
      HELD_RPT: begin
        if (fall) begin
          rcnt_nxt  = '0;
          state_nxt = RELEASED;
        end else if (!repeat_en) begin
          rcnt_nxt  = '0;
          state_nxt = HELD_DELAY;
        end else if (rcnt == RR_LAST) begin
          rpt_nxt  = 1'b1;
          rcnt_nxt = '0;
        end else begin
          rcnt_nxt = rcnt + CW'(1);
        end
      end
      default: begin
        rcnt_nxt  = '0;
        state_nxt = RELEASED;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioner top: one independent button_channel per button.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTN      = 3,
  parameter int DB_CYCLES    = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_in,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_in[i]),
      .repeat_en(repeat_en[i]),
      .level    (btn_level[i]),
      .press    (btn_press[i]),
      .rel      (btn_release[i]),
      .rpt      (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random stimulus, with
// a window-based reference model feeding a scoreboard checked every cycle.
module tb_button_conditioner;

  localparam int NB = 3;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] repeat_en = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  button_conditioner #(
    .NUM_BTN(NB), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The level flips when the last DB synchronized samples (raw delayed two
  // edges) all disagree with it and DB edges have passed since the last flip
  // or reset. Repeats fall at anchor+RD, +RR, ... where the anchor is the press
  // edge or the latest edge that saw repeat_en low while held.
  typedef struct packed {
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] rpt;
  } exp_t;

  exp_t          sb[$];
  bit            armed = 1'b0;
  logic [NB-1:0] m_s1, m_s2, m_lvl;
  int            last_chg[NB];
  int            anchor[NB];
  bit            held[NB];
  bit            hist[NB][64];
  bit            m_acc;
  int            m_t;
  exp_t          m_e;

  always @(posedge clk) begin
    cyc++;
    m_e = '0;
    if (!rst_n) begin
      armed = 1'b1;
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      for (int ch = 0; ch < NB; ch++) begin
        last_chg[ch] = cyc;
        held[ch]     = 1'b0;
      end
    end else if (armed) begin
      for (int ch = 0; ch < NB; ch++) begin
        hist[ch][cyc % 64] = m_s2[ch];
        m_acc = (cyc - last_chg[ch]) >= DB;
        for (int k = 0; k < DB; k++)
          if (hist[ch][(cyc - k) % 64] == m_lvl[ch]) m_acc = 1'b0;
        if (m_acc) begin
          m_lvl[ch]    = ~m_lvl[ch];
          last_chg[ch] = cyc;
          if (m_lvl[ch]) begin
            m_e.press[ch] = 1'b1;
            m_e.rpt[ch]   = 1'b1;
            held[ch]      = 1'b1;
            anchor[ch]    = cyc;
          end else begin
            m_e.rel[ch] = 1'b1;
            held[ch]    = 1'b0;
          end
        end else if (held[ch]) begin
          if (!repeat_en[ch]) begin
            anchor[ch] = cyc;
          end else begin
            m_t = cyc - anchor[ch];
            if (m_t >= RD && ((m_t - RD) % RR) == 0) m_e.rpt[ch] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
    m_e.level = m_lvl;
    if (armed) sb.push_back(m_e);
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("outputs", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'(mon_e));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int cp[NB], cr[NB], crp[NB];

  task automatic clear_counts();
    for (int ch = 0; ch < NB; ch++) begin
      cp[ch] = 0; cr[ch] = 0; crp[ch] = 0;
    end
  endtask

  // Advance n cycles, tallying output pulses sampled mid-cycle.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int ch = 0; ch < NB; ch++) begin
        cp[ch]  += int'(btn_press[ch]);
        cr[ch]  += int'(btn_release[ch]);
        crp[ch] += int'(btn_repeat[ch]);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all buttons held.
    btn_in = 3'b111;
    rst_n  = 1'b0;
    run(3);
    check("reset_level", 32'(btn_level), 32'd0);
    rst_n = 1'b1;
    clear_counts();
    run(6);
    check("held_reset_level", 32'(btn_level), 32'h7);
    check("held_reset_press", 32'(btn_press), 32'h7);
    run(4);
    check("held_reset_press_cnt", 32'(cp[0] + cp[1] + cp[2]), 32'd3);
    btn_in = '0;
    run(10);

    // Bounce on button 0.
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      btn_in[0] = ~btn_in[0];
      run(2);
    end
    btn_in[0] = 1'b1;
    run(12);
    check("bounce_press_cnt", 32'(cp[0]), 32'd1);
    check("bounce_release_cnt", 32'(cr[0]), 32'd0);
    btn_in[0] = 1'b0;
    run(10);

    // Glitch on button 1.
    clear_counts();
    btn_in[1] = 1'b1;
    run(3);
    btn_in[1] = 1'b0;
    run(12);
    check("glitch_pulses", 32'(cp[1] + cr[1] + crp[1]), 32'd0);

    // Auto-repeat enabled, then disabled.
    clear_counts();
    repeat_en[1] = 1'b1;
    btn_in[1]    = 1'b1;
    run(64);
    check("repeat_en_cnt", 32'(crp[1]), 32'd6);
    btn_in[1] = 1'b0;
    run(12);
    clear_counts();
    repeat_en[1] = 1'b0;
    btn_in[1]    = 1'b1;
    run(64);
    check("repeat_dis_cnt", 32'(crp[1]), 32'd1);
    btn_in[1] = 1'b0;
    run(12);

    // Simultaneous press on 0 and release on 2.
    btn_in[2] = 1'b1;
    run(10);
    btn_in[0] = 1'b1;
    btn_in[2] = 1'b0;
    run(6);
    check("simul_press_release", 32'({btn_press[0], btn_release[2]}), 32'd3);
    btn_in = '0;
    run(10);

    // Reset in the middle of auto-repeat.
    repeat_en[1] = 1'b1;
    btn_in[1]    = 1'b1;
    run(35);
    rst_n = 1'b0;
    run(1);
    check("midrpt_reset_outs", 32'({btn_level, btn_press, btn_release, btn_repeat}), 32'd0);
    rst_n = 1'b1;
    clear_counts();
    run(40);
    check("midrpt_press_cnt", 32'(cp[1]), 32'd1);
    check("midrpt_repeat_cnt", 32'(crp[1]), 32'd3);
    btn_in = '0;
    run(10);

    // Random stimulus.
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if ($urandom_range(0, 9) == 0) btn_in[ch] = ~btn_in[ch];
        if ($urandom_range(0, 59) == 0) repeat_en[ch] = ~repeat_en[ch];
      end
      rst_n = ($urandom_range(0, 499) != 0);
      run(1);
    end
    rst_n = 1'b1;
    run(3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
